i2c_temp_master: RTL and testbench
==================================

// Module: i2c_temp_master
// PURPOSE
//  I2C master (initiator) that reads a 16-bit temperature word from the sensor-side I2C responder.
//  On a start pulse it runs the sequence START, addr+R, ACK, byte0, ACK, byte1, NACK, STOP.
//  It then presents the word to the UART formatter with a one-cycle valid pulse.
//  SDA and SCL are open-drain: *_oe=1 pulls the line low; the top level ties the pull-ups.
// PARAMETERS
//  CLK_DIV     4      system clocks per quarter-bit tick (>=2); SCL period = 4*CLK_DIV clocks
//  SLAVE_ADDR  7'h48  7-bit target address; R/W bit is always 1 (read)
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   single-cycle request; ignored while busy=1
//  scl_in      in   1   resolved SCL line (clock-stretch detect)
//  sda_in      in   1   resolved SDA line
//  scl_oe      out  1   1 = pull SCL low
//  sda_oe      out  1   1 = pull SDA low
//  busy        out  1   high from the cycle after start is accepted until done
//  temp_data   out  16  {byte0,byte1}; MSB received first
//  data_valid  out  1   one-cycle pulse; temp_data is valid on that cycle
//  ack_err     out  1   one-cycle pulse when the address byte is NACKed
// BEHAVIOUR
//  Reset (async, any state): scl_oe=0, sda_oe=0 (both lines released at once).
//   busy=0, data_valid=0, ack_err=0, temp_data=16'h0000, FSM=IDLE, divider=0.
//  Tick: a free divider counts 0..CLK_DIV-1 and ticks on wrap. It is held at 0 in IDLE.
//  Bit slot = 4 ticks; phase p advances on each tick.
//   p0: scl_oe=1, set sda_oe for this bit.  p1: scl_oe=0 (release).
//   p2: SCL high; if scl_in=0 (stretch), hold p2 and the divider until scl_in=1.
//       Then sample sda_in on the tick.  p3: scl_oe=1.
//  States:
//   IDLE -> START on start=1.
//   START: sda_oe=1 while SCL is released, 2 ticks; then scl_oe=1 for 2 ticks.
//   ADDR: 8 slots of {SLAVE_ADDR,1'b1}, MSB first; sda_oe = ~bit.
//   AACK: 1 slot, SDA released. A sample of 0 goes to RD0. A sample of 1 pulses ack_err
//         and goes to STOP.
//   RD0 / RD1: 8 slots each, SDA released; shift sda_in into a 16-bit shift register.
//   MACK: slot after RD0 drives sda_oe=1 (ACK).
//   MNACK: slot after RD1 releases SDA (NACK).
//   STOP: tick0 scl_oe=1, sda_oe=1; tick1 scl_oe=0; tick2 sda_oe=0; tick3 -> DONE.
//   DONE: 1 clock. temp_data <= shift reg and data_valid=1, only if the address was ACKed.
//         busy=0 next cycle -> IDLE.
//  Latency without stretching: 116 ticks = 116*CLK_DIV clocks from start to data_valid.
//   Add +1 clock for acceptance.
//  start while busy: ignored, not queued. start on the same cycle as DONE: ignored.
//  temp_data holds its last value between transactions. After an address NACK it is unchanged.
//  sda_oe changes only while SCL is driven low, except the START/STOP edges.
//  No arbitration or multi-master support. No ACK check on read bytes.
// TESTING
//  1. Responder model at 0x48 ACKs and returns 8'h19, 8'h80.
//     -> temp_data=16'h1980, one data_valid pulse, ack_err never 1.
//  2. CLK_DIV=4, no stretch.
//     -> data_valid exactly 465 clocks after the start cycle; busy high for 464 cycles.
//  3. No responder (SDA floats high).
//     -> ack_err pulse at AACK, STOP issued, no data_valid, temp_data unchanged.
//  4. Responder holds SCL low 20 clocks during bit 3 of RD0.
//     -> master waits, data still 16'h1980, latency +20.
//  5. start pulsed mid-transaction.
//     -> ignored; exactly one data_valid for the first request.
//  6. rst_n low during RD1, then a new start.
//     -> lines released same cycle, outputs at reset values; next read is correct.
//  All: line monitor flags any SDA change while SCL is high outside START/STOP.

Source files
------------

// File: rtl/i2c_temp_master.sv
// I2C master that reads a 16-bit temperature word (addr+R, two data bytes)
// and hands it to the UART formatter with a one-cycle valid pulse.
module i2c_temp_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [6:0]  SLAVE_ADDR = 7'h48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        scl_oe,
    output logic        sda_oe,
    output logic        busy,
    output logic [15:0] temp_data,
    output logic        data_valid,
    output logic        ack_err
);
    localparam int unsigned     DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [7:0]      ADDR_BYTE = {SLAVE_ADDR, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_RD0, S_MACK, S_RD1, S_MNACK, S_STOP, S_DONE
    } state_t;

    state_t      state, state_n;
    logic [DW-1:0] div, div_n;
    logic [1:0]  phase, phase_n;
    logic [2:0]  bitcnt, bitcnt_n;
    logic [15:0] shreg, shreg_n;
    logic [15:0] temp_n;
    logic        acked, acked_n;
    logic        ack_err_n;
    logic        in_slot, hold, tick, sample, slot_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            div       <= '0;
            phase     <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            temp_data <= '0;
            acked     <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            state     <= state_n;
            div       <= div_n;
            phase     <= phase_n;
            bitcnt    <= bitcnt_n;
            shreg     <= shreg_n;
            temp_data <= temp_n;
            acked     <= acked_n;
            ack_err   <= ack_err_n;
        end
    end

    always_comb begin
        state_n    = state;
        bitcnt_n   = bitcnt;
        shreg_n    = shreg;
        temp_n     = temp_data;
        acked_n    = acked;
        ack_err_n  = 1'b0;
        scl_oe     = 1'b0;
        sda_oe     = 1'b0;
        data_valid = 1'b0;
        busy       = (state != S_IDLE) && (state != S_DONE);

        in_slot  = state inside {S_ADDR, S_AACK, S_RD0, S_MACK, S_RD1, S_MNACK};
        // Clock stretch: freeze the divider while the responder holds SCL low in p2
        hold     = in_slot && (phase == 2'd2) && !scl_in;
        tick     = busy && !hold && (div == DIV_LAST);
        sample   = tick && (phase == 2'd2);
        slot_end = tick && (phase == 2'd3);

        if (!busy)
            div_n = '0;
        else if (hold)
            div_n = div;
        else
            div_n = tick ? '0 : div + 1'b1;
        phase_n = !busy ? 2'd0 : (tick ? phase + 2'd1 : phase);

        if (in_slot)
            scl_oe = (phase == 2'd0) || (phase == 2'd3);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_START;
                    acked_n  = 1'b0;
                    bitcnt_n = '0;
                end
            end
            S_START: begin
                scl_oe = phase[1];
                sda_oe = 1'b1;
                if (slot_end) state_n = S_ADDR;
            end
            S_ADDR: begin
                sda_oe = ~ADDR_BYTE[3'd7 - bitcnt];
                if (slot_end) begin
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = S_AACK;
                end
            end
            S_AACK: begin
                if (sample) begin
                    if (sda_in) ack_err_n = 1'b1;
                    else        acked_n   = 1'b1;
                end
                if (slot_end) state_n = acked ? S_RD0 : S_STOP;
            end
            S_RD0, S_RD1: begin
                if (sample) shreg_n = {shreg[14:0], sda_in};
                if (slot_end) begin
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = (state == S_RD0) ? S_MACK : S_MNACK;
                end
            end
            S_MACK: begin
                sda_oe = 1'b1;
                if (slot_end) state_n = S_RD1;
            end
            S_MNACK: begin
                if (slot_end) state_n = S_STOP;
            end
            S_STOP: begin
                scl_oe = (phase == 2'd0);
                sda_oe = !phase[1];
                if (slot_end) begin
                    state_n = S_DONE;
                    if (acked) temp_n = shreg;
                end
            end
            S_DONE: begin
                data_valid = acked;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_temp_master.sv
// Bench for i2c_temp_master: responder model on the open-drain lines, a cycle-level
// transaction model checked every cycle, and directed scenarios with literal expectations.
module tb_i2c_temp_master;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        scl_oe, sda_oe, busy, data_valid, ack_err;
    logic [15:0] temp_data;
    logic        stretch, resp_pull;
    logic        scl_line, sda_line;

    assign scl_line = !(scl_oe || stretch);
    assign sda_line = !(sda_oe || resp_pull);

    i2c_temp_master #(.CLK_DIV(DIV), .SLAVE_ADDR(7'h48)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .scl_in(scl_line), .sda_in(sda_line),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .busy(busy),
        .temp_data(temp_data), .data_valid(data_valid), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scenario configuration, only changed while the bus is idle
    bit         cfg_present = 1'b1, cfg_stretch = 1'b0;
    logic [7:0] cfg_b0 = 8'h00, cfg_b1 = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Responder at address 0x48: decodes START/STOP and counts SCL falls; fall n sets SDA for slot n
    logic       r_active, r_ack, bus_free, scl_p, sda_p;
    int         r_n, str_cnt;
    logic [7:0] r_addr;

    function automatic logic slot_pull(input int n, input logic ack, input logic [7:0] b0, input logic [7:0] b1);
        if (n == 8)              return ack;
        if (n >= 9 && n <= 16)   return ack && !b0[16 - n];
        if (n >= 18 && n <= 25)  return ack && !b1[25 - n];
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0; r_ack <= 1'b0; bus_free <= 1'b1; r_n <= -1; r_addr <= '0;
            resp_pull <= 1'b0; stretch <= 1'b0; str_cnt <= 0; scl_p <= 1'b1; sda_p <= 1'b1;
        end else begin
            scl_p <= scl_line;
            sda_p <= sda_line;
            if (scl_p && scl_line && sda_p && !sda_line) begin
                r_active <= 1'b1; r_n <= -1; bus_free <= 1'b0; r_ack <= 1'b0;
            end else if (scl_p && scl_line && !sda_p && sda_line) begin
                r_active <= 1'b0; bus_free <= 1'b1; resp_pull <= 1'b0;
            end else if (r_active && scl_p && !scl_line) begin
                r_n <= r_n + 1;
                if (r_n + 1 == 8) begin
                    r_ack     <= cfg_present && (r_addr == 8'h91);
                    resp_pull <= cfg_present && (r_addr == 8'h91);
                end else begin
                    resp_pull <= slot_pull(r_n + 1, r_ack, cfg_b0, cfg_b1);
                end
                if (r_n + 1 == 12 && cfg_stretch) begin
                    stretch <= 1'b1; str_cnt <= 0;
                end
            end else if (r_active && !scl_p && scl_line && r_n >= 0 && r_n <= 7) begin
                r_addr <= {r_addr[6:0], sda_line};
            end
            // Keep SCL low for 20 clocks past the end of the master's release phase
            if (stretch && !scl_oe) begin
                str_cnt <= str_cnt + 1;
                if (str_cnt + 1 == DIV + 20) stretch <= 1'b0;
            end
        end
    end

    // Transaction model: cycle ages relative to acceptance, derived from the tick budget
    bit         m_active, m_present;
    int         m_age, m_len;
    logic [15:0] m_temp, m_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_age <= 0; m_len <= 0; m_temp <= '0; m_present <= 1'b0; m_word <= '0;
        end else if (m_active) begin
            m_age <= m_age + 1;
            if (m_age + 1 == m_len + 1 && m_present) m_temp <= m_word;
            if (m_age + 1 > m_len + 1) m_active <= 1'b0;
        end else if (start) begin
            m_active  <= 1'b1;
            m_age     <= 1;
            m_present <= cfg_present;
            m_word    <= {cfg_b0, cfg_b1};
            m_len     <= cfg_present ? 116 * DIV + (cfg_stretch ? 20 : 0) : 44 * DIV;
        end
    end

    int   dv_cnt, ae_cnt, busy_cnt, dv_cyc, s_cyc;
    logic mon_scl_p = 1'b1, mon_sda_p = 1'b1;
    logic legal;

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy",       busy,       m_active && m_age <= m_len);
            check("data_valid", data_valid, m_active && m_present && m_age == m_len + 1);
            check("ack_err",    ack_err,    m_active && !m_present && m_age == 39 * DIV + 1);
            check("temp_data",  temp_data,  m_temp);
            if (mon_scl_p && scl_line && sda_line != mon_sda_p) begin
                legal = (!sda_line && bus_free) ||
                        (sda_line && r_active && (r_n == 27 || (r_n == 9 && !r_ack)));
                check("sda_while_scl_high", legal, 1'b1);
            end
            if (data_valid) begin dv_cnt++; dv_cyc = cyc; end
            if (ack_err) ae_cnt++;
            if (busy) busy_cnt++;
        end
        mon_scl_p = scl_line;
        mon_sda_p = sda_line;
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 3000 && (busy || n < 2)) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            tests++; fails++;
            $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, n);
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic set_cfg(input bit present, input logic [7:0] b0, input logic [7:0] b1, input bit str);
        cfg_present = present; cfg_b0 = b0; cfg_b1 = b1; cfg_stretch = str;
        dv_cnt = 0; ae_cnt = 0; busy_cnt = 0; dv_cyc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl_oe", scl_oe, 1'b0);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_temp", temp_data, 16'h0000);
        check("rst_dv", data_valid, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Basic read and exact latency
        set_cfg(1'b1, 8'h19, 8'h80, 1'b0);
        pulse_start(); wait_idle();
        check("t1_temp", temp_data, 16'h1980);
        check("t1_dv_count", dv_cnt, 1);
        check("t1_ack_err_count", ae_cnt, 0);
        check("t1_latency", dv_cyc - s_cyc, 465);
        check("t1_busy_cycles", busy_cnt, 464);

        set_cfg(1'b1, 8'hA5, 8'h3C, 1'b0);
        pulse_start(); wait_idle();
        check("t1b_temp", temp_data, 16'hA53C);
        check("t1b_latency", dv_cyc - s_cyc, 465);

        // No responder: address NACK
        set_cfg(1'b0, 8'h19, 8'h80, 1'b0);
        pulse_start(); wait_idle();
        check("t3_ack_err_count", ae_cnt, 1);
        check("t3_dv_count", dv_cnt, 0);
        check("t3_temp_kept", temp_data, 16'hA53C);
        check("t3_busy_cycles", busy_cnt, 176);

        // Clock stretch during RD0 bit 3
        set_cfg(1'b1, 8'h19, 8'h80, 1'b1);
        pulse_start(); wait_idle();
        check("t4_temp", temp_data, 16'h1980);
        check("t4_latency", dv_cyc - s_cyc, 485);
        check("t4_busy_cycles", busy_cnt, 484);
        check("t4_dv_count", dv_cnt, 1);

        // start while busy and on the DONE cycle
        set_cfg(1'b1, 8'h5A, 8'hC3, 1'b0);
        pulse_start();
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        begin
            int n = 0;
            while (n < 1000 && !data_valid) begin @(posedge clk); #1; n++; end
            if (n >= 1000) begin
                tests++; fails++;
                $display("FAIL t5_dv_timeout: data_valid not seen in %0d cycles", n);
            end
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("t5_busy_after", busy, 1'b0);
        check("t5_dv_count", dv_cnt, 1);
        check("t5_temp", temp_data, 16'h5AC3);
        check("t5_latency", dv_cyc - s_cyc, 465);

        // Reset during RD1, then a fresh read
        set_cfg(1'b1, 8'h12, 8'h34, 1'b0);
        pulse_start();
        repeat (340) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_scl_oe", scl_oe, 1'b0);
        check("t6_sda_oe", sda_oe, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_temp", temp_data, 16'h0000);
        check("t6_dv", data_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        set_cfg(1'b1, 8'h19, 8'h80, 1'b0);
        pulse_start(); wait_idle();
        check("t6_temp_after", temp_data, 16'h1980);
        check("t6_latency", dv_cyc - s_cyc, 465);
        check("t6_dv_count", dv_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
